// File: rtl/ad7946_emulator.sv
`default_nettype none
// ============================================================================
// Module   : ad7946_emulator
// Purpose  : Serial-side responder model of the AD7946 ADC for FPGA loopback.
//            Optional macro AD7946_EMU_RAMP_EN replaces the sample ports with
//            internal per-channel ramps.
// Revision : 1.0 - initial release
// ============================================================================
module ad7946_emulator #(
    parameter int CONV_CYCLES = 8,
    parameter int SYNC_STAGES = 2,
    parameter int WORD_BITS   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cs_n,
    input  logic        sclk,
    input  logic        chsel,
    input  logic        pden,
    input  logic [13:0] ch0_sample,
    input  logic [13:0] ch1_sample,
    output logic        sdo,
    output logic        sdo_oe,
    output logic        conv_done,
    output logic        overrun
);

    localparam int CNT_W = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CONVERT = 2'd1;
    localparam logic [1:0] ST_READY   = 2'd2;
    localparam logic [1:0] ST_SHIFT   = 2'd3;

    // Synchronizer bit order: {pden, chsel, sclk, cs_n}; idle level has cs_n high.
    logic [3:0] sync_q [SYNC_STAGES];
    logic       cs_d;
    logic       sclk_d;

    logic [1:0]           state;
    logic [CNT_W-1:0]     count;
    logic [13:0]          cap_sample;
    logic [13:0]          result;
    logic [WORD_BITS-1:0] shift_reg;

    logic                 cs_s;
    logic                 sclk_s;
    logic                 chsel_s;
    logic                 pden_s;
    logic                 cs_rise;
    logic                 cs_fall;
    logic                 sclk_fall;
    logic [13:0]          sel_sample;
    logic [WORD_BITS-1:0] load_word;

    assign cs_s      = sync_q[SYNC_STAGES-1][0];
    assign sclk_s    = sync_q[SYNC_STAGES-1][1];
    assign chsel_s   = sync_q[SYNC_STAGES-1][2];
    assign pden_s    = sync_q[SYNC_STAGES-1][3];
    assign cs_rise   = cs_s & ~cs_d;
    assign cs_fall   = ~cs_s & cs_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign load_word = WORD_BITS'(result);

`ifdef AD7946_EMU_RAMP_EN
    logic [13:0] ramp0;
    logic [13:0] ramp1;
    logic        cap_ch;
    logic        unused_samples;

    assign unused_samples = ^{ch0_sample, ch1_sample};
    assign sel_sample     = chsel_s ? ramp1 : ramp0;
`else
    assign sel_sample     = chsel_s ? ch1_sample : ch0_sample;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= 4'b0001;
            end
            cs_d   <= 1'b1;
            sclk_d <= 1'b0;
        end else begin
            sync_q[0] <= {pden, chsel, sclk, cs_n};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            cs_d   <= cs_s;
            sclk_d <= sclk_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            count      <= '0;
            cap_sample <= '0;
            result     <= '0;
            shift_reg  <= '0;
            sdo        <= 1'b0;
            sdo_oe     <= 1'b0;
            conv_done  <= 1'b0;
            overrun    <= 1'b0;
`ifdef AD7946_EMU_RAMP_EN
            ramp0      <= 14'h0000;
            ramp1      <= 14'h3FFF;
            cap_ch     <= 1'b0;
`endif
        end else begin
            conv_done <= 1'b0;
            overrun   <= 1'b0;
            sdo_oe    <= ~cs_s & ~pden_s;

            if (pden_s) begin
                // Edges seen while powered down are dropped, not deferred.
                state  <= ST_IDLE;
                sdo    <= 1'b0;
                result <= '0;
            end else if (cs_rise) begin
                state      <= ST_CONVERT;
                cap_sample <= sel_sample;
                count      <= CNT_W'(CONV_CYCLES - 1);
                sdo        <= 1'b0;
`ifdef AD7946_EMU_RAMP_EN
                cap_ch     <= chsel_s;
`endif
            end else begin
                case (state)
                    ST_CONVERT: begin
                        if (cs_fall) begin
                            // Early frame: abandon and replay the previous result.
                            overrun   <= 1'b1;
                            shift_reg <= load_word;
                            sdo       <= load_word[WORD_BITS-1];
                            state     <= ST_SHIFT;
                        end else if (count == '0) begin
                            result    <= cap_sample;
                            conv_done <= 1'b1;
                            state     <= ST_READY;
`ifdef AD7946_EMU_RAMP_EN
                            if (cap_ch) begin
                                ramp1 <= ramp1 - 14'd1;
                            end else begin
                                ramp0 <= ramp0 + 14'd1;
                            end
`endif
                        end else begin
                            count <= count - 1'b1;
                        end
                    end
                    ST_READY: begin
                        if (cs_fall) begin
                            shift_reg <= load_word;
                            sdo       <= load_word[WORD_BITS-1];
                            state     <= ST_SHIFT;
                        end
                    end
                    ST_SHIFT: begin
                        // Zero fill makes sdo fall to 0 once the word is exhausted.
                        if (sclk_fall) begin
                            sdo       <= shift_reg[WORD_BITS-2];
                            shift_reg <= {shift_reg[WORD_BITS-2:0], 1'b0};
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ad7946_emulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_ad7946_emulator
// Purpose  : Directed, scoreboard-based bench for ad7946_emulator.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ad7946_emulator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cs_n = 1'b1;
    logic        sclk = 1'b0;
    logic        chsel = 1'b0;
    logic        pden = 1'b0;
    logic [13:0] ch0_sample = 14'h0000;
    logic [13:0] ch1_sample = 14'h0000;
    wire         sdo;
    wire         sdo_oe;
    wire         conv_done;
    wire         overrun;

    ad7946_emulator #(
        .CONV_CYCLES(8),
        .SYNC_STAGES(2),
        .WORD_BITS  (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cs_n      (cs_n),
        .sclk      (sclk),
        .chsel     (chsel),
        .pden      (pden),
        .ch0_sample(ch0_sample),
        .ch1_sample(ch1_sample),
        .sdo       (sdo),
        .sdo_oe    (sdo_oe),
        .conv_done (conv_done),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int ovr_cnt = 0;
    int exp_done = 0;
    int exp_ovr = 0;
    logic [13:0] model_result = 14'h0000;
    logic [13:0] m_ramp0 = 14'h0000;
    logic [13:0] m_ramp1 = 14'h3FFF;
    logic [15:0] exp_q [$];

    always @(negedge clk) begin
        if (conv_done === 1'b1) done_cnt++;
        if (overrun === 1'b1) ovr_cnt++;
    end

    initial begin
        #500us;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [13:0] sample_of(input logic ch);
`ifdef AD7946_EMU_RAMP_EN
        return ch ? m_ramp1 : m_ramp0;
`else
        return ch ? ch1_sample : ch0_sample;
`endif
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        wait_clk(2);
        rst_n = 1'b1;
        model_result = 14'h0000;
        m_ramp0 = 14'h0000;
        m_ramp1 = 14'h3FFF;
        wait_clk(4);
    endtask

    // Holds cs_n high for 'hold' clocks; 10 or more lets the conversion finish.
    task automatic start_conv(input logic ch, input int hold);
        logic [13:0] val;
        chsel = ch;
        cs_n  = 1'b1;
        wait_clk(hold);
        if (hold >= 10) begin
            val = sample_of(ch);
            model_result = val;
            exp_done++;
            if (ch) m_ramp1 = m_ramp1 - 14'd1;
            else    m_ramp0 = m_ramp0 + 14'd1;
        end else begin
            val = model_result;
            exp_ovr++;
        end
        exp_q.push_back({2'b00, val});
        cs_n = 1'b0;
    endtask

    task automatic read_bits(input int n, output logic [31:0] bits);
        bits = '0;
        wait_clk(4);
        for (int k = 0; k < n; k++) begin
            bits = {bits[30:0], sdo};
            sclk = 1'b1;
            wait_clk(4);
            sclk = 1'b0;
            wait_clk(4);
        end
    endtask

    task automatic frame(input string tag, input int n);
        logic [31:0] bits;
        logic [31:0] e;
        read_bits(n, bits);
        check({tag, "_oe"}, {31'b0, sdo_oe}, 32'd1);
        if (exp_q.size() == 0) begin
            check({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
            e = {16'b0, exp_q.pop_front()};
            if (n >= 16) e = e << (n - 16);
            else         e = e >> (16 - n);
            check(tag, bits, e);
        end
    endtask

    task automatic drop_expected();
        if (exp_q.size() != 0) void'(exp_q.pop_front());
    endtask

    initial begin
        logic [31:0] junk;

        // Reset values
        wait_clk(3);
        check("rst_sdo",       {31'b0, sdo},       32'd0);
        check("rst_sdo_oe",    {31'b0, sdo_oe},    32'd0);
        check("rst_conv_done", {31'b0, conv_done}, 32'd0);
        check("rst_overrun",   {31'b0, overrun},   32'd0);
        rst_n = 1'b1;
        cs_n  = 1'b0;
        wait_clk(6);
        check("idle_sdo",      {31'b0, sdo},       32'd0);
        check("idle_no_done",  done_cnt,           32'd0);

        // Basic frame
        ch0_sample = 14'h2A5C;
        start_conv(1'b0, 10);
        frame("t1_word", 16);
        check("t1_done_once",  done_cnt, 32'd1);
        check("t1_no_overrun", ovr_cnt,  32'd0);

        // Channel alternation
        ch0_sample = 14'h0001;
        ch1_sample = 14'h3FFE;
        for (int i = 0; i < 4; i++) begin
            start_conv(i[0], 12);
            frame($sformatf("t2_frame%0d", i), 16);
        end

        // Overrun after reset returns 0, then returns the previous result
        do_reset();
        start_conv(1'b0, 4);
        frame("t3_overrun_zero", 16);
        check("t3_ovr_cnt", ovr_cnt, exp_ovr);
        start_conv(1'b1, 12);
        frame("t3_full", 16);
        start_conv(1'b0, 4);
        frame("t3_overrun_prev", 16);
        check("t3_ovr_cnt2", ovr_cnt, exp_ovr);

        // Over-long frame, partial frame, then restart at MSB
        ch0_sample = 14'h1FFF;
        ch1_sample = 14'h3FFF;
        start_conv(1'b1, 12);
        frame("t4_long", 20);
        start_conv(1'b0, 12);
        frame("t4_partial", 5);
        start_conv(1'b1, 12);
        frame("t4_after", 16);

        // Reset mid-frame
        ch0_sample = 14'h3C3C;
        ch1_sample = 14'h0A0A;
        start_conv(1'b0, 12);
        read_bits(6, junk);
        rst_n = 1'b0;
        wait_clk(1);
        check("t5_rst_sdo",    {31'b0, sdo},    32'd0);
        check("t5_rst_sdo_oe", {31'b0, sdo_oe}, 32'd0);
        drop_expected();
        rst_n = 1'b1;
        model_result = 14'h0000;
        m_ramp0 = 14'h0000;
        m_ramp1 = 14'h3FFF;
        wait_clk(4);
        start_conv(1'b1, 12);
        frame("t5_after_rst", 16);

        // Power-down mid-frame clears the result
        start_conv(1'b0, 12);
        read_bits(6, junk);
        pden = 1'b1;
        wait_clk(3);
        check("t5_pden_sdo",    {31'b0, sdo},    32'd0);
        check("t5_pden_sdo_oe", {31'b0, sdo_oe}, 32'd0);
        drop_expected();
        cs_n = 1'b1;
        wait_clk(4);
        cs_n = 1'b0;
        wait_clk(4);
        check("t5_pden_ignore", {31'b0, sdo_oe}, 32'd0);
        pden = 1'b0;
        model_result = 14'h0000;
        wait_clk(4);
        start_conv(1'b0, 4);
        frame("t5_pden_zero", 16);
        start_conv(1'b0, 12);
        frame("t5_after_pden", 16);

`ifdef AD7946_EMU_RAMP_EN
        do_reset();
        for (int i = 0; i < 3; i++) begin
            start_conv(1'b0, 12);
            frame($sformatf("t6_ramp0_%0d", i), 16);
        end
        for (int i = 0; i < 2; i++) begin
            start_conv(1'b1, 12);
            frame($sformatf("t6_ramp1_%0d", i), 16);
        end
`endif

        wait_clk(4);
        check("final_done_cnt", done_cnt, exp_done);
        check("final_ovr_cnt",  ovr_cnt,  exp_ovr);
        check("final_queue",    exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
